apb_exe_unit_q: RTL and testbench

//  APB slave giving the master a queued arithmetic execution unit.
//  - Writes push jobs {oper,argA,argB} into a command FIFO.
//  - An internal multi-cycle engine executes them in order.
//  - Results and status flags are pushed into a result FIFO, which the master pops by APB reads.
//  - Sits on the shared APB bus beside the other execution-unit slaves, selected by one PSEL bit.

---
 rtl/apb_exe_unit_q.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_apb_exe_unit_q.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_exe_unit_q.sv
// rtl/apb_exe_unit_q.sv - APB slave with queued multi-cycle arithmetic execution unit

// Circular FIFO with an extra pointer bit so full and empty are distinguishable.
module apb_exe_unit_q_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_PCLK,
    input  logic                     i_PRESETn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards every entry and wins over push/pop.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only visible through valid pointers so no reset.
    always_ff @(posedge i_PCLK) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module apb_exe_unit_q #(
    parameter int SEL_WIDTH  = 3,
    parameter int SEL_BIT    = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int OPER_WIDTH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int EXE_LAT    = 2
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [SEL_WIDTH-1:0]  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic                  o_PSLVERR,
    output logic [DATA_WIDTH-1:0] o_PRDATA
);
    localparam int ARG_W = DATA_WIDTH / 2;
    localparam int MSB   = ARG_W - 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CMD_W = OPER_WIDTH + 2 * ARG_W;
    localparam int RES_W = ARG_W + 4;
    localparam int CNT_W = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;

    localparam logic [ADDR_WIDTH-1:0] A_ARGS   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_CMD    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_RESULT = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_STAT   = ADDR_WIDTH'(3);

    localparam logic [OPER_WIDTH-1:0] OP_ADD = OPER_WIDTH'(0);
    localparam logic [OPER_WIDTH-1:0] OP_SUB = OPER_WIDTH'(1);
    localparam logic [OPER_WIDTH-1:0] OP_AND = OPER_WIDTH'(2);
    localparam logic [OPER_WIDTH-1:0] OP_XOR = OPER_WIDTH'(3);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EXEC = 1'b1;

    logic                  acc;
    logic                  xfer;
    logic                  flush;
    logic [DATA_WIDTH-1:0] args;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] stat_word;

    logic                  cmd_push;
    logic                  cmd_pop;
    logic [CMD_W-1:0]      cmd_data;
    logic [AW:0]           cmd_count;
    logic                  cmd_full;
    logic                  cmd_empty;

    logic                  res_push;
    logic                  res_pop;
    logic [RES_W-1:0]      res_data;
    logic [AW:0]           res_count;
    logic                  res_full;
    logic                  res_empty;

    logic                  state;
    logic [CNT_W-1:0]      cnt;
    logic [OPER_WIDTH-1:0] job_oper;
    logic [ARG_W-1:0]      job_a;
    logic [ARG_W-1:0]      job_b;
    logic                  issue;
    logic                  done;

    logic [ARG_W:0]        sum_ext;
    logic [ARG_W-1:0]      alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic                  alu_inv;

    logic                  unused_psel;
    assign unused_psel = ^i_PSEL;

    assign acc  = i_PSEL[SEL_BIT] & i_PENABLE;
    assign xfer = acc & ~o_PREADY;

    assign flush    = xfer & i_PWRITE & (i_PADDR == A_STAT) & i_PWDATA[0];
    assign cmd_push = xfer & i_PWRITE & (i_PADDR == A_CMD) & ~cmd_full;
    assign res_pop  = xfer & ~i_PWRITE & (i_PADDR == A_RESULT) & ~res_empty;

    assign issue    = (state == ST_IDLE) & ~cmd_empty & ~res_full;
    assign done     = (state == ST_EXEC) & (cnt == '0);
    assign cmd_pop  = issue & ~flush;
    assign res_push = done & ~flush;

    apb_exe_unit_q_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .i_PCLK    (i_PCLK),
        .i_PRESETn (i_PRESETn),
        .flush     (flush),
        .push      (cmd_push),
        .push_data ({i_PWDATA[OPER_WIDTH-1:0], args[2*ARG_W-1:0]}),
        .pop       (cmd_pop),
        .pop_data  (cmd_data),
        .count     (cmd_count),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    apb_exe_unit_q_fifo #(.W(RES_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .i_PCLK    (i_PCLK),
        .i_PRESETn (i_PRESETn),
        .flush     (flush),
        .push      (res_push),
        .push_data ({alu_inv, alu_v, alu_c, (alu_res == '0), alu_res}),
        .pop       (res_pop),
        .pop_data  (res_data),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty)
    );

    // Engine arithmetic on the latched job; flags use two's complement rules.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_inv = 1'b0;
        case (job_oper)
            OP_ADD: begin
                sum_ext = {1'b0, job_a} + {1'b0, job_b};
                alu_res = sum_ext[ARG_W-1:0];
                alu_c   = sum_ext[ARG_W];
                alu_v   = (job_a[MSB] == job_b[MSB]) && (alu_res[MSB] != job_a[MSB]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, job_a} - {1'b0, job_b};
                alu_res = sum_ext[ARG_W-1:0];
                alu_c   = sum_ext[ARG_W];
                alu_v   = (job_a[MSB] != job_b[MSB]) && (alu_res[MSB] != job_a[MSB]);
            end
            OP_AND:  alu_res = job_a & job_b;
            OP_XOR:  alu_res = job_a ^ job_b;
            default: alu_inv = 1'b1;
        endcase
    end

    // Engine FSM: take one job from the command FIFO, run EXE_LAT cycles, emit the result.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            job_oper <= '0;
            job_a    <= '0;
            job_b    <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (issue) begin
                state    <= ST_EXEC;
                cnt      <= CNT_W'(EXE_LAT - 1);
                job_a    <= cmd_data[ARG_W-1:0];
                job_b    <= cmd_data[2*ARG_W-1:ARG_W];
                job_oper <= cmd_data[CMD_W-1:2*ARG_W];
            end
        end else begin
            if (cnt == '0)
                state <= ST_IDLE;
            else
                cnt <= cnt - 1'b1;
        end
    end

    // Status word: queue occupancies in the low bytes, engine busy in the top bit.
    always_comb begin
        stat_word                 = '0;
        stat_word[DATA_WIDTH-1]   = (state == ST_EXEC);
        stat_word[15:8]           = 8'(cmd_count);
        stat_word[7:0]            = 8'(res_count);
    end

    // Read data and error decode for the access currently on the bus.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (i_PADDR)
            A_ARGS: begin
                if (!i_PWRITE)
                    rd_data = args;
            end
            A_CMD: begin
                rd_err = i_PWRITE ? cmd_full : 1'b1;
            end
            A_RESULT: begin
                if (i_PWRITE || res_empty)
                    rd_err = 1'b1;
                else
                    rd_data = {{(DATA_WIDTH-RES_W){1'b0}}, res_data};
            end
            A_STAT: begin
                if (!i_PWRITE)
                    rd_data = stat_word;
            end
            default: ;
        endcase
    end

    // Operand register, written only by completed ARGS accesses.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn)
            args <= '0;
        else if (xfer && i_PWRITE && (i_PADDR == A_ARGS))
            args <= i_PWDATA;
    end

    // APB response: one wait state, response fields zero whenever PREADY is low.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            o_PREADY  <= 1'b0;
            o_PSLVERR <= 1'b0;
            o_PRDATA  <= '0;
        end else if (xfer) begin
            o_PREADY  <= 1'b1;
            o_PSLVERR <= rd_err;
            o_PRDATA  <= rd_data;
        end else begin
            o_PREADY  <= 1'b0;
            o_PSLVERR <= 1'b0;
            o_PRDATA  <= '0;
        end
    end
endmodule

// File: tb/tb_apb_exe_unit_q.sv
// tb/tb_apb_exe_unit_q.sv - scoreboard bench for apb_exe_unit_q

module tb_apb_exe_unit_q;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [1:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    always #5 clk = ~clk;

    apb_exe_unit_q dut (
        .i_PCLK    (clk),
        .i_PRESETn (rstn),
        .i_PSEL    (psel),
        .i_PENABLE (penable),
        .i_PWRITE  (pwrite),
        .i_PADDR   (paddr),
        .i_PWDATA  (pwdata),
        .o_PREADY  (pready),
        .o_PSLVERR (pslverr),
        .o_PRDATA  (prdata)
    );

    // kind 0: exact compare; kind 1: STAT occupancy total (cmd+res+busy) equals data
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_q[$];
    int          outstanding = 0;
    logic [31:0] last_args = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: result word computed with plain integer arithmetic.
    function automatic logic [31:0] ref_op(input int op, input int a, input int b);
        int r, sa, sbv, sr;
        logic c, v;
        logic [15:0] r16;
        sa  = (a >= 32768) ? a - 65536 : a;
        sbv = (b >= 32768) ? b - 65536 : b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 65535); sr = sa + sbv; v = (sr > 32767) || (sr < -32768); end
            1: begin r = a - b; c = (a < b);     sr = sa - sbv; v = (sr > 32767) || (sr < -32768); end
            2: r = a & b;
            default: r = a ^ b;
        endcase
        r16 = r[15:0];
        return {12'b0, 1'b0, v, c, (r16 == 16'h0), r16};
    endfunction

    // Monitor: every PREADY pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   total;
        if (rstn === 1'b1) begin
            if (pready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
                    if (e.kind == 1) begin
                        total = int'(prdata[15:8]) + int'(prdata[7:0]) + int'(prdata[31]);
                        check({e.name, "_occupancy"}, total, e.data);
                        check({e.name, "_reserved"}, {17'b0, prdata[30:16]}, 32'd0);
                    end else if (e.chk_data) begin
                        check({e.name, "_prdata"}, prdata, e.data);
                    end
                end
            end else begin
                check("idle_outputs", prdata | {31'b0, pslverr} | {31'b0, pready}, 32'd0);
            end
        end
    end

    task automatic apb(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                       input int kind, input logic [31:0] edata, input logic eerr,
                       input logic chkd, input string name, output logic [31:0] rd);
        exp_t e;
        @(posedge clk); #1;
        psel = 3'b100; pwrite = wr; paddr = addr; pwdata = wd; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        e.kind = kind; e.data = edata; e.err = eerr; e.chk_data = chkd; e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        check({name, "_ready_timing"}, {31'b0, pready}, 32'd1);
        rd = prdata;
        psel = '0; penable = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic err, input string n);
        logic [31:0] dummy;
        apb(1'b1, a, d, 0, 32'h0, err, 1'b0, n, dummy);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input logic err, input string n);
        logic [31:0] dummy;
        apb(1'b0, a, 32'h0, 0, exp, err, 1'b1, n, dummy);
    endtask

    task automatic rd_stat(input string n, output logic [31:0] v);
        apb(1'b0, 2'd3, 32'h0, 1, outstanding, 1'b0, 1'b1, n, v);
    endtask

    task automatic push_job_exp(input int op, input int a, input int b, input logic [31:0] exp);
        last_args = {b[15:0], a[15:0]};
        wr(2'd0, last_args, 1'b0, "args_wr");
        wr(2'd1, op, 1'b0, "cmd_wr");
        model_q.push_back(exp);
        outstanding++;
    endtask

    task automatic push_job(input int op, input int a, input int b);
        push_job_exp(op, a, b, ref_op(op, a, b));
    endtask

    task automatic pop_job();
        logic [31:0] v;
        int          tries;
        tries = 0;
        v = '0;
        while (tries < 40) begin
            rd_stat("stat_poll", v);
            if (v[7:0] != 8'd0) break;
            tries++;
        end
        if (v[7:0] == 8'd0) begin
            check("result_poll_timeout", 32'd1, 32'd0);
        end else begin
            rd(2'd2, model_q.pop_front(), 1'b0, "result");
            outstanding--;
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] v;
        int          jobs;
        #1;
        check("reset_outputs", prdata | {31'b0, pslverr} | {31'b0, pready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        rd(2'd0, 32'h0, 1'b0, "reset_args");
        rd(2'd3, 32'h0, 1'b0, "reset_stat");

        // First result: not yet readable at T+3, readable on the next read.
        wr(2'd0, 32'h0003_0005, 1'b0, "t1_args");
        wr(2'd1, 32'h0, 1'b0, "t1_cmd");
        rd(2'd2, 32'h0, 1'b1, "t1_early_result");
        rd(2'd2, 32'h0000_0008, 1'b0, "t1_result");

        // Flag corner cases.
        push_job_exp(0, 16'hFFFF, 1, 32'h0003_0000);
        pop_job();
        push_job_exp(1, 16'h8000, 1, 32'h0004_7FFF);
        pop_job();

        // Illegal access directions.
        rd(2'd1, 32'h0, 1'b1, "cmd_read");
        wr(2'd2, 32'h1234, 1'b1, "result_write");
        wr(2'd3, 32'h0, 1'b0, "stat_write_noflush");

        // Fill results, then commands, then overflow the command FIFO.
        for (int i = 0; i < 4; i++) push_job($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535));
        repeat (30) @(posedge clk);
        for (int i = 0; i < 4; i++) push_job($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535));
        wr(2'd0, 32'h0001_0001, 1'b0, "full_args");
        wr(2'd1, 32'h0, 1'b1, "cmd_full_push");
        rd(2'd3, 32'h0000_0404, 1'b0, "stat_full");
        while (model_q.size() > 0) pop_job();
        rd(2'd2, 32'h0, 1'b1, "result_empty");

        // Randomized mix of pushes and pops, many pointer wraps.
        jobs = 0;
        for (int it = 0; it < 80; it++) begin
            if (outstanding < 3 && ($urandom_range(0, 2) != 0 || outstanding == 0)) begin
                push_job($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535));
                jobs++;
            end else begin
                pop_job();
            end
            if ($urandom_range(0, 7) == 0) rd(2'd0, last_args, 1'b0, "args_readback");
        end
        while (model_q.size() > 0) pop_job();
        check("random_jobs_min", {31'b0, (jobs >= 10)}, 32'd1);

        // Flush while the engine is executing.
        push_job(0, 1, 2);
        push_job(3, 16'h00FF, 16'h0F0F);
        wr(2'd3, 32'h1, 1'b0, "flush");
        model_q.delete();
        outstanding = 0;
        rd(2'd3, 32'h0, 1'b0, "stat_after_flush");
        rd(2'd2, 32'h0, 1'b1, "result_after_flush");

        // Asynchronous reset in the middle of a transfer and a job.
        push_job(1, 9, 4);
        @(posedge clk); #1;
        psel = 3'b100; pwrite = 1'b0; paddr = 2'd3; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", prdata | {31'b0, pslverr} | {31'b0, pready}, 32'd0);
        psel = '0; penable = 1'b0;
        model_q.delete();
        outstanding = 0;
        last_args = '0;
        @(posedge clk); #1 rstn = 1'b1;
        rd(2'd3, 32'h0, 1'b0, "stat_after_reset");
        rd(2'd0, 32'h0, 1'b0, "args_after_reset");
        rd(2'd2, 32'h0, 1'b1, "result_after_reset");

        // Traffic addressed to other slaves must be ignored.
        push_job(2, 16'hF0F0, 16'h3C3C);
        repeat (10) @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            psel = 3'($urandom_range(0, 3));
            penable = 1'($urandom_range(0, 1));
            pwrite = 1'b1;
            paddr = 2'($urandom_range(0, 3));
            pwdata = 32'hFFFF_FFFF;
        end
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        rd(2'd0, last_args, 1'b0, "other_sel_args");
        rd(2'd3, 32'h0000_0001, 1'b0, "other_sel_stat");
        pop_job();

        repeat (5) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
